instr_mem_port_arbiter: RTL and testbench

- Shares port b of the 4x8-bit byte-lane instruction SRAM wrapper between two requesters.
  - Requester 0: core load/store side.
  - Requester 1: host configuration/DMA loader.
- Enforces the conf_sel mode split: in configuration mode only the loader reaches memory; in running mode the core has weighted priority with starvation protection.
- Routes read data back to the issuing requester after the fixed SRAM read latency.

---
 rtl/instr_mem_port_arbiter_if.sv | 57 +++++
 rtl/instr_mem_port_arbiter.sv | 129 ++++++++++++
 tb/tb_instr_mem_port_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_mem_port_arbiter_if.sv
// Purpose : bundles the requester handshakes, the mode select and the
//           SRAM port-b command/data bus of instr_mem_port_arbiter.
// Modports: slave  - arbiter view (requests/conf_sel/mem_dout in,
//                    readies/responses/mem command out)
//           master - environment view (requesters, host and SRAM model)
interface instr_mem_port_arbiter_if;
  logic        conf_sel;
  logic        conf_active;

  logic        req0_valid;
  logic        req0_ready;
  logic        req0_we;
  logic [31:0] req0_addr;
  logic [31:0] req0_wdata;
  logic [3:0]  req0_wstrb;

  logic        req1_valid;
  logic        req1_ready;
  logic        req1_we;
  logic [31:0] req1_addr;
  logic [31:0] req1_wdata;
  logic [3:0]  req1_wstrb;

  logic        resp0_valid;
  logic [31:0] resp0_rdata;
  logic        resp1_valid;
  logic [31:0] resp1_rdata;

  logic        mem_we;
  logic        mem_rd;
  logic [31:0] mem_addr;
  logic [31:0] mem_din;
  logic [3:0]  mem_strb;
  logic [31:0] mem_dout;

  modport slave (
    input  conf_sel,
    input  req0_valid, req0_we, req0_addr, req0_wdata, req0_wstrb,
    input  req1_valid, req1_we, req1_addr, req1_wdata, req1_wstrb,
    input  mem_dout,
    output conf_active,
    output req0_ready, req1_ready,
    output resp0_valid, resp0_rdata, resp1_valid, resp1_rdata,
    output mem_we, mem_rd, mem_addr, mem_din, mem_strb
  );

  modport master (
    output conf_sel,
    output req0_valid, req0_we, req0_addr, req0_wdata, req0_wstrb,
    output req1_valid, req1_we, req1_addr, req1_wdata, req1_wstrb,
    output mem_dout,
    input  conf_active,
    input  req0_ready, req1_ready,
    input  resp0_valid, resp0_rdata, resp1_valid, resp1_rdata,
    input  mem_we, mem_rd, mem_addr, mem_din, mem_strb
  );
endinterface

// File: rtl/instr_mem_port_arbiter.sv
// Purpose : shares port b of the instruction SRAM wrapper between the core
//           load/store side (requester 0) and the host config/DMA loader
//           (requester 1). Configuration mode admits only the loader; run
//           mode gives the core weighted priority with a burst limit so the
//           loader cannot starve. Read data is routed back to the issuer
//           MEM_LAT cycles after acceptance.
// Ports   : clk  - system clock
//           rst  - asynchronous reset, active-high
//           bus  - instr_mem_port_arbiter_if.slave (handshakes, mode, SRAM)
//
// state | meaning
// RUN   | weighted arbitration, core preferred up to MAX_BURST grants
// DRAIN | no grants; wait for in-flight reads to return
// CONF  | loader only; core held off
module instr_mem_port_arbiter #(
  parameter int unsigned MAX_BURST = 4,
  parameter int unsigned MEM_LAT   = 1
) (
  input  logic clk,
  input  logic rst,
  instr_mem_port_arbiter_if.slave bus
);

  localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    DRAIN = 2'd1,
    CONF  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [3:0]         burst_q, burst_d;
  logic [MEM_LAT-1:0] pv_q, pv_d;
  logic [MEM_LAT-1:0] pid_q, pid_d;

  logic gnt0, gnt1;
  logic rd_accept;
  logic pipe_empty;
  logic pipe_out_v;
  logic pipe_out_id;

  assign pipe_empty  = ~|pv_q;
  assign pipe_out_v  = pv_q[MEM_LAT-1];
  assign pipe_out_id = pid_q[MEM_LAT-1];

  // Mode FSM and grant decode
  always_comb begin
    state_d = state_q;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    case (state_q)
      RUN: begin
        gnt1 = bus.req1_valid & (~bus.req0_valid | (burst_q == BURST_LIMIT));
        gnt0 = bus.req0_valid & ~gnt1;
        if (bus.conf_sel) state_d = DRAIN;
      end
      DRAIN: begin
        // exit target follows conf_sel every cycle, so a short glitch
        // simply drains and falls back to RUN
        if (pipe_empty) state_d = bus.conf_sel ? CONF : RUN;
      end
      CONF: begin
        gnt1 = bus.req1_valid;
        if (!bus.conf_sel) state_d = DRAIN;
      end
      default: state_d = RUN;
    endcase
    // readies and the command bus must read 0 while reset is held
    if (rst) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
  end

  // Consecutive core grants while the loader waits
  always_comb begin
    burst_d = burst_q;
    if ((state_q != RUN) || !bus.req1_valid || gnt1) begin
      burst_d = '0;
    end else if (gnt0 && (burst_q != BURST_LIMIT)) begin
      burst_d = burst_q + 4'd1;
    end
  end

  assign rd_accept = (gnt0 & ~bus.req0_we) | (gnt1 & ~bus.req1_we);

  // Read-return pipe: stage 0 takes the new read, last stage is the response
  always_comb begin
    pv_d     = '0;
    pid_d    = '0;
    pv_d[0]  = rd_accept;
    pid_d[0] = gnt1;
    for (int i = 1; i < MEM_LAT; i++) begin
      pv_d[i]  = pv_q[i-1];
      pid_d[i] = pid_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RUN;
      burst_q <= '0;
      pv_q    <= '0;
      pid_q   <= '0;
    end else begin
      state_q <= state_d;
      burst_q <= burst_d;
      pv_q    <= pv_d;
      pid_q   <= pid_d;
    end
  end

  assign bus.conf_active = (state_q == CONF);
  assign bus.req0_ready  = gnt0;
  assign bus.req1_ready  = gnt1;

  assign bus.mem_we   = (gnt0 & bus.req0_we) | (gnt1 & bus.req1_we);
  assign bus.mem_rd   = rd_accept;
  assign bus.mem_addr = gnt1 ? bus.req1_addr  : (gnt0 ? bus.req0_addr  : '0);
  assign bus.mem_din  = gnt1 ? bus.req1_wdata : (gnt0 ? bus.req0_wdata : '0);
  assign bus.mem_strb = gnt1 ? bus.req1_wstrb : (gnt0 ? bus.req0_wstrb : '0);

  assign bus.resp0_valid = pipe_out_v & ~pipe_out_id;
  assign bus.resp1_valid = pipe_out_v &  pipe_out_id;
  assign bus.resp0_rdata = bus.resp0_valid ? bus.mem_dout : '0;
  assign bus.resp1_rdata = bus.resp1_valid ? bus.mem_dout : '0;

endmodule

// File: tb/tb_instr_mem_port_arbiter.sv
// Bench for instr_mem_port_arbiter: DUT A runs MEM_LAT=1, DUT B MEM_LAT=2,
// both MAX_BURST=4. Read responses go through per-DUT expectation queues
// checked by independent monitors; grant/command checks are made inline.
module tb_instr_mem_port_arbiter;

  typedef struct {
    logic        id;
    logic [31:0] data;
    int unsigned cyc;
  } exp_t;

  logic clk;
  logic rst;
  int unsigned cyc;
  int vectors;
  int miscompares;

  exp_t qa[$];
  exp_t qb[$];
  exp_t ea;
  exp_t eb;

  logic [31:0] douta;
  logic [31:0] db1;
  logic [31:0] db2;

  instr_mem_port_arbiter_if ifa ();
  instr_mem_port_arbiter_if ifb ();

  instr_mem_port_arbiter #(.MAX_BURST(4), .MEM_LAT(1)) u_dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa)
  );

  instr_mem_port_arbiter #(.MAX_BURST(4), .MEM_LAT(2)) u_dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] memf(input logic [31:0] addr);
    if (addr == 32'h10) return 32'hDEADBEEF;
    return {16'hC0DE, addr[15:0]};
  endfunction

  // SRAM models with the matching read latency
  always @(posedge clk) begin
    if (ifa.mem_rd) douta <= memf(ifa.mem_addr);
    if (ifb.mem_rd) db1 <= memf(ifb.mem_addr);
    db2 <= db1;
  end
  assign ifa.mem_dout = douta;
  assign ifb.mem_dout = db2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, required %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Response monitors
  always @(negedge clk) begin
    if (ifa.resp0_valid || ifa.resp1_valid) begin
      chk("A resp_onehot", {31'b0, ifa.resp0_valid & ifa.resp1_valid}, 32'd0);
      if (qa.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL A unexpected_resp: got resp0=%b resp1=%b, required none (cycle %0d)",
                 ifa.resp0_valid, ifa.resp1_valid, cyc);
      end else begin
        ea = qa.pop_front();
        chk("A resp_id", {31'b0, ifa.resp1_valid}, {31'b0, ea.id});
        chk("A resp_data", ifa.resp1_valid ? ifa.resp1_rdata : ifa.resp0_rdata, ea.data);
        chk("A resp_cycle", cyc, ea.cyc);
      end
    end
  end

  always @(negedge clk) begin
    if (ifb.resp0_valid || ifb.resp1_valid) begin
      chk("B resp_onehot", {31'b0, ifb.resp0_valid & ifb.resp1_valid}, 32'd0);
      if (qb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL B unexpected_resp: got resp0=%b resp1=%b, required none (cycle %0d)",
                 ifb.resp0_valid, ifb.resp1_valid, cyc);
      end else begin
        eb = qb.pop_front();
        chk("B resp_id", {31'b0, ifb.resp1_valid}, {31'b0, eb.id});
        chk("B resp_data", ifb.resp1_valid ? ifb.resp1_rdata : ifb.resp0_rdata, eb.data);
        chk("B resp_cycle", cyc, eb.cyc);
      end
    end
  end

  task automatic a_r0(input logic v, input logic we, input logic [31:0] addr);
    ifa.req0_valid = v; ifa.req0_we = we; ifa.req0_addr = addr;
    ifa.req0_wdata = 32'h0; ifa.req0_wstrb = 4'hF;
  endtask

  task automatic a_r1(input logic v, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] strb);
    ifa.req1_valid = v; ifa.req1_we = we; ifa.req1_addr = addr;
    ifa.req1_wdata = wdata; ifa.req1_wstrb = strb;
  endtask

  task automatic b_r0(input logic v, input logic we, input logic [31:0] addr);
    ifb.req0_valid = v; ifb.req0_we = we; ifb.req0_addr = addr;
    ifb.req0_wdata = 32'h0; ifb.req0_wstrb = 4'hF;
  endtask

  task automatic b_r1(input logic v, input logic we, input logic [31:0] addr);
    ifb.req1_valid = v; ifb.req1_we = we; ifb.req1_addr = addr;
    ifb.req1_wdata = 32'h0; ifb.req1_wstrb = 4'hF;
  endtask

  logic [9:0] starve_seq;
  logic [4:0] rerun_seq;

  initial begin
    cyc = 0;
    vectors = 0;
    miscompares = 0;
    starve_seq = 10'b10_0001_0000;
    rerun_seq  = 5'b1_0000;
    rst = 1'b1;
    ifa.conf_sel = 1'b0;
    ifb.conf_sel = 1'b0;
    a_r0(1'b1, 1'b0, 32'h77);
    a_r1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    b_r0(1'b1, 1'b0, 32'h77);
    b_r1(1'b1, 1'b1, 32'h78);

    // Outputs held at 0 while reset is asserted, even with requests present
    mid();
    chk("rst A req0_ready", {31'b0, ifa.req0_ready}, 32'd0);
    chk("rst A mem_rd", {31'b0, ifa.mem_rd}, 32'd0);
    chk("rst A mem_addr", ifa.mem_addr, 32'd0);
    chk("rst A conf_active", {31'b0, ifa.conf_active}, 32'd0);
    chk("rst B req1_ready", {31'b0, ifb.req1_ready}, 32'd0);
    chk("rst B mem_we", {31'b0, ifb.mem_we}, 32'd0);
    tick();
    rst = 1'b0;
    a_r0(1'b0, 1'b0, 32'h0);
    b_r0(1'b0, 1'b0, 32'h0);
    b_r1(1'b0, 1'b0, 32'h0);
    tick();

    // Reset mid-run on B with two reads in flight: no response may follow
    b_r0(1'b1, 1'b0, 32'h40);
    mid();
    chk("B inflight rd0 ready", {31'b0, ifb.req0_ready}, 32'd1);
    tick();
    b_r0(1'b0, 1'b0, 32'h0);
    b_r1(1'b1, 1'b0, 32'h44);
    mid();
    chk("B inflight rd1 ready", {31'b0, ifb.req1_ready}, 32'd1);
    tick();
    b_r1(1'b0, 1'b0, 32'h0);
    rst = 1'b1;
    mid();
    chk("B midrst resp0_valid", {31'b0, ifb.resp0_valid}, 32'd0);
    chk("B midrst resp1_valid", {31'b0, ifb.resp1_valid}, 32'd0);
    chk("B midrst mem_rd", {31'b0, ifb.mem_rd}, 32'd0);
    tick();
    rst = 1'b0;
    repeat (3) tick();
    b_r0(1'b1, 1'b1, 32'h48);
    mid();
    chk("B post_rst run ready0", {31'b0, ifb.req0_ready}, 32'd1);
    chk("B post_rst conf_active", {31'b0, ifb.conf_active}, 32'd0);
    tick();
    b_r0(1'b0, 1'b0, 32'h0);

    // Single read on A, MEM_LAT=1
    tick();
    a_r0(1'b1, 1'b0, 32'h10);
    mid();
    chk("A single ready0", {31'b0, ifa.req0_ready}, 32'd1);
    chk("A single mem_rd", {31'b0, ifa.mem_rd}, 32'd1);
    chk("A single mem_addr", ifa.mem_addr, 32'h10);
    chk("A single mem_we", {31'b0, ifa.mem_we}, 32'd0);
    qa.push_back('{1'b0, 32'hDEADBEEF, cyc + 1});
    tick();
    a_r0(1'b0, 1'b0, 32'h0);
    tick();

    // Starvation protection: both writers held for 10 cycles
    a_r0(1'b1, 1'b1, 32'h80);
    a_r1(1'b1, 1'b1, 32'h84, 32'h1, 4'hF);
    for (int i = 0; i < 10; i++) begin
      if (i > 0) tick();
      mid();
      chk($sformatf("A starve gnt1[%0d]", i), {31'b0, ifa.req1_ready}, {31'b0, starve_seq[i]});
      chk($sformatf("A starve gnt0[%0d]", i), {31'b0, ifa.req0_ready}, {31'b0, ~starve_seq[i]});
    end
    tick();
    a_r0(1'b0, 1'b0, 32'h0);
    a_r1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    tick();

    // Mode switch with a read in flight
    a_r0(1'b1, 1'b0, 32'h30);
    a_r1(1'b1, 1'b1, 32'h20, 32'hA5A5A5A5, 4'b0011);
    ifa.conf_sel = 1'b1;
    mid();
    chk("A sw ready0", {31'b0, ifa.req0_ready}, 32'd1);
    chk("A sw ready1", {31'b0, ifa.req1_ready}, 32'd0);
    chk("A sw mem_rd", {31'b0, ifa.mem_rd}, 32'd1);
    qa.push_back('{1'b0, 32'hC0DE0030, cyc + 1});
    for (int i = 0; i < 2; i++) begin
      tick();
      mid();
      chk("A drain ready0", {31'b0, ifa.req0_ready}, 32'd0);
      chk("A drain ready1", {31'b0, ifa.req1_ready}, 32'd0);
      chk("A drain conf_active", {31'b0, ifa.conf_active}, 32'd0);
      chk("A drain mem_we", {31'b0, ifa.mem_we | ifa.mem_rd}, 32'd0);
    end
    tick();
    mid();
    chk("A conf conf_active", {31'b0, ifa.conf_active}, 32'd1);
    chk("A conf ready0", {31'b0, ifa.req0_ready}, 32'd0);
    chk("A conf ready1", {31'b0, ifa.req1_ready}, 32'd1);
    chk("A conf mem_we", {31'b0, ifa.mem_we}, 32'd1);
    chk("A conf mem_strb", {28'b0, ifa.mem_strb}, 32'h3);
    chk("A conf mem_addr", ifa.mem_addr, 32'h20);
    chk("A conf mem_din", ifa.mem_din, 32'hA5A5A5A5);
    tick();
    mid();
    chk("A conf2 ready0", {31'b0, ifa.req0_ready}, 32'd0);
    chk("A conf2 ready1", {31'b0, ifa.req1_ready}, 32'd1);
    tick();
    a_r0(1'b0, 1'b0, 32'h0);
    a_r1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    // Return to run
    tick();
    ifa.conf_sel = 1'b0;
    a_r0(1'b1, 1'b1, 32'h50);
    mid();
    chk("A ret conf_active", {31'b0, ifa.conf_active}, 32'd1);
    chk("A ret ready0", {31'b0, ifa.req0_ready}, 32'd0);
    tick();
    mid();
    chk("A ret drain conf_active", {31'b0, ifa.conf_active}, 32'd0);
    chk("A ret drain ready0", {31'b0, ifa.req0_ready}, 32'd0);
    tick();
    a_r1(1'b1, 1'b1, 32'h60, 32'h2, 4'hF);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      mid();
      chk($sformatf("A rerun gnt1[%0d]", i), {31'b0, ifa.req1_ready}, {31'b0, rerun_seq[i]});
      chk($sformatf("A rerun gnt0[%0d]", i), {31'b0, ifa.req0_ready}, {31'b0, ~rerun_seq[i]});
    end
    tick();
    a_r0(1'b0, 1'b0, 32'h0);
    a_r1(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);

    // conf_sel glitch on B: grant in the rise cycle, drain, back to RUN
    tick();
    ifb.conf_sel = 1'b1;
    b_r0(1'b1, 1'b1, 32'h90);
    mid();
    chk("B glitch rise ready0", {31'b0, ifb.req0_ready}, 32'd1);
    tick();
    ifb.conf_sel = 1'b0;
    mid();
    chk("B glitch drain ready0", {31'b0, ifb.req0_ready}, 32'd0);
    chk("B glitch conf_active", {31'b0, ifb.conf_active}, 32'd0);
    tick();
    mid();
    chk("B glitch run ready0", {31'b0, ifb.req0_ready}, 32'd1);
    tick();
    b_r0(1'b0, 1'b0, 32'h0);

    // MEM_LAT=2 back-to-back reads alternating requesters
    tick();
    b_r0(1'b1, 1'b0, 32'h100);
    mid();
    chk("B pipe rd0 ready", {31'b0, ifb.req0_ready}, 32'd1);
    qb.push_back('{1'b0, 32'hC0DE0100, cyc + 2});
    tick();
    b_r0(1'b0, 1'b0, 32'h0);
    b_r1(1'b1, 1'b0, 32'h104);
    mid();
    chk("B pipe rd1 ready", {31'b0, ifb.req1_ready}, 32'd1);
    qb.push_back('{1'b1, 32'hC0DE0104, cyc + 2});
    tick();
    b_r1(1'b0, 1'b0, 32'h0);
    b_r0(1'b1, 1'b0, 32'h108);
    mid();
    chk("B pipe rd2 ready", {31'b0, ifb.req0_ready}, 32'd1);
    qb.push_back('{1'b0, 32'hC0DE0108, cyc + 2});
    tick();
    b_r0(1'b0, 1'b0, 32'h0);
    repeat (6) tick();
    mid();

    chk("A resp queue drained", qa.size(), 32'd0);
    chk("B resp queue drained", qb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
